// File: rtl/cla_issue_retire.sv
// Issue/retire controller around a fixed-latency, non-stallable pipelined CLA adder.
// Operands are registered onto the adder, results captured into a FWFT FIFO under credit control.
module cla_issue_retire #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned LAT        = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_a,
  input  logic [WIDTH-1:0]              in_b,
  input  logic                          in_cin,
  output logic [WIDTH-1:0]              add_a,
  output logic [WIDTH-1:0]              add_b,
  output logic                          add_cin,
  input  logic [WIDTH-1:0]              add_sum,
  input  logic                          add_cout,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_sum,
  output logic                          out_cout,
  output logic [$clog2(FIFO_DEPTH):0]   in_flight
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [LAT:0]       v;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [WIDTH:0]     mem [FIFO_DEPTH];

  logic               in_fire_c;
  logic               push_c;
  logic               pop_c;
  logic [CNT_W-1:0]   flight_c;
  logic [OCC_W-1:0]   occupancy_c;

  // Ops issued but not yet retired into the FIFO.
  always_comb begin
    flight_c = '0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      flight_c = flight_c + CNT_W'(v[k]);
    end
  end

  // Credit: every outstanding op (queued or in the adder) owns a FIFO slot; same-cycle pops are ignored.
  always_comb begin
    occupancy_c = OCC_W'(count) + OCC_W'(flight_c);
    in_ready    = !rst && (occupancy_c < OCC_W'(FIFO_DEPTH));
    in_fire_c   = in_valid && in_ready;
    out_valid   = !rst && (count != '0);
    pop_c       = out_valid && out_ready;
    push_c      = v[LAT];
    in_flight   = rst ? '0 : flight_c;
    out_sum     = mem[rd_ptr][WIDTH-1:0];
    out_cout    = mem[rd_ptr][WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_a   <= '0;
      add_b   <= '0;
      add_cin <= 1'b0;
      v       <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (in_fire_c) begin
        add_a   <= in_a;
        add_b   <= in_b;
        add_cin <= in_cin;
      end
      v <= {v[LAT-1:0], in_fire_c};
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity is carried by count.
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem[wr_ptr] <= {add_cout, add_sum};
  end

endmodule

// File: tb/tb_cla_issue_retire.sv
// Randomized bench for cla_issue_retire with a behavioural adder and a queue-based reference model.
module tb_cla_issue_retire;

  localparam int W     = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_cin;
  logic [W-1:0]  add_a;
  logic [W-1:0]  add_b;
  logic          add_cin;
  logic [W-1:0]  add_sum;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_sum;
  logic          out_cout;
  logic [3:0]    in_flight;

  cla_issue_retire #(.WIDTH(W), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .in_flight(in_flight)
  );

  always #5 clk = ~clk;

  // Adder stand-in: samples its inputs every edge, result stable LAT edges after sampling, never reset.
  logic [W:0] pipe [LAT];
  always_ff @(posedge clk) begin
    pipe[0] <= (W+1)'(add_a) + (W+1)'(add_b) + (W+1)'(add_cin);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_sum  = pipe[LAT-1][W-1:0];
  assign add_cout = pipe[LAT-1][W];

  typedef struct {
    logic [W:0] exp;
    int         fe;
  } op_t;

  op_t        q[$];
  int         ecnt;
  int         n_tests;
  int         n_fail;
  int         fires;
  int         pops;
  logic [W:0] last_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, ecnt);
    end
  endtask

  // Every op is outstanding from its issue edge until popped; it is visible LAT+1 edges after issue.
  task automatic check_outputs();
    int fl;
    bit ov;
    fl = 0;
    foreach (q[i]) if (ecnt < q[i].fe + LAT + 1) fl++;
    ov = (q.size() > 0) && (ecnt >= q[0].fe + LAT + 1);
    check("in_ready", 32'(in_ready), 32'(!rst && (q.size() < DEPTH)));
    check("out_valid", 32'(out_valid), 32'(!rst && ov));
    check("in_flight", 32'(in_flight), rst ? 32'd0 : 32'(fl));
    check("outstanding_bound", 32'(q.size() <= DEPTH), 32'd1);
  endtask

  task automatic cycle(input bit iv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit c, input bit ordy);
    bit fire;
    bit pop;
    logic [W:0] e;
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_cin    = c;
    out_ready = ordy;
    #1;
    fire = in_valid && in_ready;
    pop  = out_valid && out_ready;
    e    = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
    if (pop) begin
      if (q.size() == 0) check("pop_when_empty", 32'd1, 32'd0);
      else check("result", 32'({out_cout, out_sum}), 32'(q[0].exp));
      last_out = {out_cout, out_sum};
    end
    @(posedge clk);
    ecnt++;
    if (rst) q.delete();
    else begin
      if (pop && q.size() > 0) void'(q.pop_front());
      if (fire) q.push_back('{e, ecnt});
    end
    fires += int'(fire);
    pops  += int'(pop);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0, ordy);
  endtask

  initial begin
    int n, f0, p0;
    n_tests = 0; n_fail = 0; fires = 0; pops = 0; ecnt = 0; last_out = '0;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;

    idle(2, 1'b0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_add_cin", 32'(add_cin), 32'd0);
    rst = 1'b0;
    idle(1, 1'b1);

    // 1: single op latency and value
    f0 = fires;
    cycle(1'b1, 16'h1234, 16'h0F0F, 1'b0, 1'b1);
    check("t1_fired", 32'(fires - f0), 32'd1);
    n = 1;
    while (!out_valid && n < 20) begin
      idle(1, 1'b1);
      n++;
    end
    check("t1_latency", 32'(n), 32'd6);
    idle(1, 1'b1);
    check("t1_value", 32'(last_out), 32'h02143);

    // 2: carry-out wrap and carry-in
    cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    idle(8, 1'b1);
    check("t2_wrap", 32'(last_out), 32'h10000);
    cycle(1'b1, 16'h7FFF, 16'h0000, 1'b1, 1'b1);
    idle(8, 1'b1);
    check("t2_cin", 32'(last_out), 32'h08000);

    // 3: 32 back-to-back ops with a free-running consumer
    f0 = fires; p0 = pops;
    for (int i = 0; i < 32; i++) begin
      if (i > 0) check("t3_ready_held", 32'(in_ready), 32'd1);
      cycle(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b1);
    end
    idle(10, 1'b1);
    check("t3_fires", 32'(fires - f0), 32'd32);
    check("t3_pops", 32'(pops - p0), 32'd32);

    // 4: stalled consumer fills exactly DEPTH, then drains
    f0 = fires;
    for (int i = 0; i < 12; i++)
      cycle(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
    check("t4_accepted", 32'(fires - f0), 32'(DEPTH));
    check("t4_ready_low", 32'(in_ready), 32'd0);
    p0 = pops;
    idle(12, 1'b1);
    check("t4_drained", 32'(pops - p0), 32'(DEPTH));
    check("t4_ready_back", 32'(in_ready), 32'd1);

    // 5: 200 ops under random back-pressure
    f0 = fires; p0 = pops; n = 0;
    while (fires - f0 < 200 && n < 4000) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom()), 16'($urandom()), 1'($urandom()),
            1'($urandom()));
      n++;
    end
    check("t5_issued", 32'(fires - f0), 32'd200);
    idle(20, 1'b1);
    check("t5_retired", 32'(pops - p0), 32'd200);

    // 6: reset with 3 ops in the adder and 2 queued
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1'b0);
    idle(2, 1'b0);
    check("t6_pre_inflight", 32'(in_flight), 32'd3);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    idle(1, 1'b1);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_inflight", 32'(in_flight), 32'd0);
    rst = 1'b0;
    p0 = pops;
    cycle(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1);
    idle(12, 1'b1);
    check("t6_single_result", 32'(pops - p0), 32'd1);
    check("t6_value", 32'(last_out), 32'h00002);
    check("final_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
